// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one unified memory port between the instruction-fetch path and the
// load/store path. One transaction is outstanding at a time. Its response is
// routed back to the requester that issued it.
//
// Ports:
//   clk, nreset                 clock (rising edge), async active-low reset
//   if_req/if_addr              fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata   fetch grant pulse, response pulse, data
//   d_req/d_rw/d_addr/
//   d_wdata/d_wstrobe           load/store request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata      data grant pulse, response pulse, data
//   m_req/m_rw/m_addr/
//   m_wdata/m_wstrobe           memory-side request, held until m_ack
//   m_ack/m_rdata               memory completion and read data
//   stall                       core must hold pc and writeback this cycle
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_rw,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrobe,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req,
    output logic                m_rw,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrobe,
    input  logic                m_ack,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                stall
);

    localparam int STRB_W = DATA_W / 8;
    // A counter of width 0 is not legal, so MAX_WAIT=0 still gets one bit.
    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_IF = 2'd1;
    localparam logic [1:0] ST_BUSY_D  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] starve_cnt;
    logic             idle;

    assign idle = (state == ST_IDLE);

    // Data normally wins contention; once data has won MAX_WAIT contended
    // grants in a row, fetch is forced through.
    assign if_gnt = idle & if_req & (~d_req | (starve_cnt == CNT_MAX));
    assign d_gnt  = idle & d_req & ~if_gnt;

    // The memory request is simply "a transaction is in flight", so it drops
    // the moment reset forces the FSM back to IDLE.
    assign m_req = ~idle;

    assign stall = ~idle | (if_req & ~if_gnt) | (d_req & ~d_gnt);

    // FSM plus the latched memory-side request fields. Fetches never write.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= ST_IDLE;
            m_rw      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_wstrobe <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (if_gnt) begin
                        state     <= ST_BUSY_IF;
                        m_rw      <= 1'b0;
                        m_addr    <= if_addr;
                        m_wstrobe <= '0;
                    end else if (d_gnt) begin
                        state     <= ST_BUSY_D;
                        m_rw      <= d_rw;
                        m_addr    <= d_addr;
                        m_wdata   <= d_wdata;
                        m_wstrobe <= d_rw ? d_wstrobe : STRB_W'(0);
                    end
                end
                ST_BUSY_IF, ST_BUSY_D: begin
                    if (m_ack) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Response routing: the rvalid pulse lands the cycle after m_ack, and the
    // rdata registers keep their value between pulses.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if (m_ack && state == ST_BUSY_IF) begin
                if_rvalid <= 1'b1;
                if_rdata  <= m_rdata;
            end
            if (m_ack && state == ST_BUSY_D) begin
                d_rvalid <= 1'b1;
                d_rdata  <= m_rw ? DATA_W'(0) : m_rdata;
            end
        end
    end

    // Starvation counter: counts data grants that beat a waiting fetch.
    // It only clears when fetch is served or fetch stops asking while idle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            starve_cnt <= '0;
        end else if (if_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && if_req) begin
            if (starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else if (idle && !if_req) begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Two instances share all inputs: dut4
// uses MAX_WAIT=4 and dut2 uses MAX_WAIT=2. Only the starvation sequence
// looks at dut2. Inputs change 1 time unit after a rising edge. Outputs are
// checked 1 unit later, well before the next edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        nreset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrobe;
    logic        m_ack;
    logic [31:0] m_rdata;

    logic        if_gnt4, if_rvalid4, d_gnt4, d_rvalid4, m_req4, m_rw4, stall4;
    logic [31:0] if_rdata4, d_rdata4, m_addr4, m_wdata4;
    logic [3:0]  m_wstrobe4;

    logic        if_gnt2, if_rvalid2, d_gnt2, d_rvalid2, m_req2, m_rw2, stall2;
    logic [31:0] if_rdata2, d_rdata2, m_addr2, m_wdata2;
    logic [3:0]  m_wstrobe2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut4 (
        .clk(clk), .nreset(nreset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt4),
        .if_rvalid(if_rvalid4), .if_rdata(if_rdata4),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrobe(d_wstrobe), .d_gnt(d_gnt4), .d_rvalid(d_rvalid4),
        .d_rdata(d_rdata4),
        .m_req(m_req4), .m_rw(m_rw4), .m_addr(m_addr4), .m_wdata(m_wdata4),
        .m_wstrobe(m_wstrobe4), .m_ack(m_ack), .m_rdata(m_rdata),
        .stall(stall4)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(2)) dut2 (
        .clk(clk), .nreset(nreset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt2),
        .if_rvalid(if_rvalid2), .if_rdata(if_rdata2),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrobe(d_wstrobe), .d_gnt(d_gnt2), .d_rvalid(d_rvalid2),
        .d_rdata(d_rdata2),
        .m_req(m_req2), .m_rw(m_rw2), .m_addr(m_addr2), .m_wdata(m_wdata2),
        .m_wstrobe(m_wstrobe2), .m_ack(m_ack), .m_rdata(m_rdata),
        .stall(stall2)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive every DUT input for the current cycle, then let combinational
    // outputs settle.
    task automatic applyStimulus(input logic ifr, input logic [31:0] ia,
                                 input logic dr, input logic drw,
                                 input logic [31:0] da, input logic [31:0] dwd,
                                 input logic [3:0] dws, input logic ack,
                                 input logic [31:0] rd);
        if_req    = ifr;
        if_addr   = ia;
        d_req     = dr;
        d_rw      = drw;
        d_addr    = da;
        d_wdata   = dwd;
        d_wstrobe = dws;
        m_ack     = ack;
        m_rdata   = rd;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Short reset pulse that sits between clock edges.
    task automatic pulseReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
        nreset = 1'b0;
        #2;
        nreset = 1'b1;
    endtask

    // Watchdog so the bench always ends even if something stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seq2 [6];
        int seq4 [6];
        int n2;
        int n4;

        // ---------------- reset state ----------------
        nreset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
        checkOutput("rst_m_req",     m_req4,     0);
        checkOutput("rst_m_addr",    m_addr4,    0);
        checkOutput("rst_m_wstrobe", m_wstrobe4, 0);
        checkOutput("rst_if_rvalid", if_rvalid4, 0);
        checkOutput("rst_d_rdata",   d_rdata4,   0);
        checkOutput("rst_stall",     stall4,     0);
        #9;
        nreset = 1'b1;

        // ---------------- lone fetch ----------------
        nextCycle();
        applyStimulus(1, 32'h8000_0000, 0, 0, 0, 0, 4'h0, 0, 0);     // cycle 0
        checkOutput("lf_if_gnt_c0", if_gnt4, 1);
        checkOutput("lf_stall_c0",  stall4,  0);
        checkOutput("lf_m_req_c0",  m_req4,  0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 4'h0, 0, 0);                 // cycle 1
        checkOutput("lf_m_req_c1",  m_req4,  1);
        checkOutput("lf_m_addr_c1", m_addr4, 32'h8000_0000);
        checkOutput("lf_m_rw_c1",   m_rw4,   0);
        checkOutput("lf_stall_c1",  stall4,  1);
        nextCycle();                                                   // cycle 2
        checkOutput("lf_m_req_c2",  m_req4,  1);
        checkOutput("lf_stall_c2",  stall4,  1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 4'h0, 1, 32'h0050_0093);     // cycle 3
        checkOutput("lf_m_req_c3",     m_req4,     1);
        checkOutput("lf_stall_c3",     stall4,     1);
        checkOutput("lf_if_rvalid_c3", if_rvalid4, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 4'h0, 0, 0);                 // cycle 4
        checkOutput("lf_if_rvalid_c4", if_rvalid4, 1);
        checkOutput("lf_if_rdata_c4",  if_rdata4,  32'h0050_0093);
        checkOutput("lf_m_req_c4",     m_req4,     0);
        checkOutput("lf_stall_c4",     stall4,     0);
        nextCycle();                                                   // cycle 5
        checkOutput("lf_if_rvalid_c5", if_rvalid4, 0);
        checkOutput("lf_if_rdata_hold", if_rdata4, 32'h0050_0093);

        // ---------------- contention, MAX_WAIT=4 ----------------
        applyStimulus(1, 32'h8000_0004, 1, 0, 32'h100, 0, 4'h0, 0, 0); // cycle 0
        checkOutput("ct_d_gnt_c0",  d_gnt4,  1);
        checkOutput("ct_if_gnt_c0", if_gnt4, 0);
        checkOutput("ct_stall_c0",  stall4,  1);
        nextCycle();
        applyStimulus(1, 32'h8000_0004, 0, 0, 0, 0, 4'h0, 1, 32'h1234_5678); // cycle 1
        checkOutput("ct_m_addr_c1", m_addr4, 32'h100);
        checkOutput("ct_if_gnt_c1", if_gnt4, 0);
        nextCycle();
        applyStimulus(1, 32'h8000_0004, 0, 0, 0, 0, 4'h0, 0, 0);     // cycle 2
        checkOutput("ct_d_rvalid_c2", d_rvalid4, 1);
        checkOutput("ct_d_rdata_c2",  d_rdata4,  32'h1234_5678);
        checkOutput("ct_if_gnt_c2",   if_gnt4,   1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 4'h0, 1, 32'hCAFE_0001);     // cycle 3
        checkOutput("ct_m_addr_c3", m_addr4, 32'h8000_0004);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 4'h0, 0, 0);                 // cycle 4
        checkOutput("ct_if_rvalid_c4", if_rvalid4, 1);
        checkOutput("ct_if_rdata_c4",  if_rdata4,  32'hCAFE_0001);
        checkOutput("ct_d_rvalid_c4",  d_rvalid4,  0);

        // ---------------- starvation: both requesters always asking ----------------
        nextCycle();
        pulseReset();
        for (int i = 0; i < 6; i++) begin
            seq2[i] = 0;
            seq4[i] = 0;
        end
        n2 = 0;
        n4 = 0;
        // 1 = data grant, 2 = fetch grant; a grant every other cycle.
        for (int cyc = 0; cyc < 14; cyc++) begin
            nextCycle();
            applyStimulus(1, 32'h8000_0100, 1, 0, 32'h200, 0, 4'h0, 1, 32'h0);
            if (n2 < 6 && (d_gnt2 || if_gnt2)) begin
                seq2[n2] = if_gnt2 ? 2 : 1;
                n2++;
            end
            if (n4 < 6 && (d_gnt4 || if_gnt4)) begin
                seq4[n4] = if_gnt4 ? 2 : 1;
                n4++;
            end
        end
        checkOutput("sv2_g0", seq2[0], 1);
        checkOutput("sv2_g1", seq2[1], 1);
        checkOutput("sv2_g2", seq2[2], 2);
        checkOutput("sv2_g3", seq2[3], 1);
        checkOutput("sv2_g4", seq2[4], 1);
        checkOutput("sv2_g5", seq2[5], 2);
        checkOutput("sv4_g3", seq4[3], 1);
        checkOutput("sv4_g4", seq4[4], 2);
        checkOutput("sv4_g5", seq4[5], 1);

        // ---------------- byte write ----------------
        nextCycle();
        pulseReset();
        nextCycle();
        applyStimulus(0, 0, 1, 1, 32'h104, 32'hAB, 4'b0001, 0, 0);   // cycle 0
        checkOutput("bw_d_gnt_c0", d_gnt4, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 4'h0, 0, 0);                 // cycle 1
        checkOutput("bw_m_req_c1",     m_req4,     1);
        checkOutput("bw_m_rw_c1",      m_rw4,      1);
        checkOutput("bw_m_wstrobe_c1", m_wstrobe4, 4'b0001);
        checkOutput("bw_m_wdata_c1",   m_wdata4,   32'hAB);
        checkOutput("bw_m_addr_c1",    m_addr4,    32'h104);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 4'h0, 1, 32'hDEAD_BEEF);     // cycle 2
        checkOutput("bw_m_rw_c2",      m_rw4,      1);
        checkOutput("bw_m_wstrobe_c2", m_wstrobe4, 4'b0001);
        nextCycle();
        // Fetch issued in the rvalid cycle; stale data-side strobes present.
        applyStimulus(1, 32'h300, 0, 1, 0, 0, 4'hF, 0, 0);           // cycle 3
        checkOutput("bw_d_rvalid_c3", d_rvalid4, 1);
        checkOutput("bw_d_rdata_c3",  d_rdata4,  0);
        checkOutput("bw_if_gnt_c3",   if_gnt4,   1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 4'h0, 1, 32'h77);            // cycle 4
        checkOutput("bf_m_rw",      m_rw4,      0);
        checkOutput("bf_m_wstrobe", m_wstrobe4, 0);
        checkOutput("bf_m_addr",    m_addr4,    32'h300);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 4'h0, 0, 0);

        // ---------------- reset mid-read ----------------
        nextCycle();
        applyStimulus(1, 32'h200, 0, 0, 0, 0, 4'h0, 0, 0);           // cycle 0
        checkOutput("rm_if_gnt_c0", if_gnt4, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 4'h0, 0, 0);                 // cycle 1
        checkOutput("rm_m_req_c1", m_req4, 1);
        nextCycle();                                                   // cycle 2
        nreset = 1'b0;
        #1;
        checkOutput("rm_m_req_async", m_req4, 0);
        checkOutput("rm_stall_async", stall4, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 4'h0, 1, 32'hBAD0_BAD0);     // cycle 3
        #1;
        nreset = 1'b1;
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 4'h0, 0, 0);                 // cycle 4
        checkOutput("rm_if_rvalid_c4", if_rvalid4, 0);
        checkOutput("rm_m_req_c4",     m_req4,     0);
        checkOutput("rm_if_rdata_c4",  if_rdata4,  0);
        nextCycle();                                                   // cycle 5
        checkOutput("rm_if_rvalid_c5", if_rvalid4, 0);

        // ---------------- stray ack while idle ----------------
        applyStimulus(0, 0, 0, 0, 0, 0, 4'h0, 1, 32'h5555_5555);
        nextCycle();
        checkOutput("sa_m_req_a",     m_req4,     0);
        checkOutput("sa_if_rvalid_a", if_rvalid4, 0);
        checkOutput("sa_d_rvalid_a",  d_rvalid4,  0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
        checkOutput("sa_if_rvalid_b", if_rvalid4, 0);
        checkOutput("sa_d_rvalid_b",  d_rvalid4,  0);
        checkOutput("sa_starve_cnt",  32'(dut4.starve_cnt), 0);
        checkOutput("sa_m_req_b",     m_req4,     0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
